fifo_ctrl_16: RTL
=================

Name: fifo_ctrl_16

Overview:
- Pointer and flag controller that turns a 16x8 synchronous dual-address RAM into a synchronous FIFO.
- Accepts push/pop requests from producer/consumer logic and drives the RAM's write, read, wr_add and rd_add inputs.
- Write data goes straight from the producer to the RAM d_in; this block never touches data.
- Reports occupancy, full/empty and threshold flags, sticky overflow/underflow errors, and a read-valid strobe aligned with the RAM's registered read data.

Parameters:
- ADDR_W, 4, RAM address width; FIFO depth is 2**ADDR_W (16).
- AF_LEVEL, 14, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- push  input  1  producer write request; data presented on RAM d_in the same cycle
- pop  input  1  consumer read request
- clr_err  input  1  synchronous clear of overflow/underflow
- ram_write  output  1  RAM write strobe (combinational)
- ram_read  output  1  RAM read strobe (combinational)
- ram_wr_add  output  ADDR_W  RAM write address
- ram_rd_add  output  ADDR_W  RAM read address
- rd_valid  output  1  RAM d_out holds popped data this cycle
- count  output  ADDR_W+1  current occupancy, 0..16
- full  output  1  count == 16
- empty  output  1  count == 0
- almost_full  output  1  count >= AF_LEVEL
- almost_empty  output  1  count <= AE_LEVEL
- overflow  output  1  sticky: a push was rejected
- underflow  output  1  sticky: a pop was rejected

Behaviour:
- Reset (async, immediate, also mid-operation):
  - wr_ptr = rd_ptr = 0, count = 0, rd_valid = 0, overflow = underflow = 0.
  - Hence empty = 1, full = 0, almost_empty = 1, almost_full = 0, ram_wr_add = ram_rd_add = 0.
  - RAM contents are not cleared; stale data is unreachable because empty = 1.
- Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits (extra wrap bit). ram_wr_add = wr_ptr[ADDR_W-1:0]; ram_rd_add = rd_ptr[ADDR_W-1:0]. Pointers increment by 1 and wrap naturally (15 -> 0 on address, wrap bit toggles).
- Acceptance (combinational):
  - pop_ok = pop & !empty.
  - push_ok = push & (!full | pop_ok).
  - ram_write = push_ok; ram_read = pop_ok.
- Update on clk rising edge:
  - push_ok: wr_ptr + 1.
  - pop_ok: rd_ptr + 1.
  - count: +1 for push_ok only, -1 for pop_ok only, unchanged for both or neither.
- Flags: full, empty, almost_full and almost_empty are decoded combinationally from the count register (registered source, no input dependence).
- Latency: rd_valid <= pop_ok on the same edge that the RAM captures d_out. Popped data and rd_valid therefore appear together one cycle after the pop request. A single-cycle pop gives a one-cycle rd_valid pulse.
- Simultaneous push+pop:
  - When full: both accepted, count stays 16. The RAM reads the old entry before overwrite, because both addresses equal the same location.
  - When empty: push accepted, pop rejected (underflow set), count becomes 1. There is no fall-through.
  - Otherwise: both accepted, count unchanged.
- Errors:
  - overflow sets on push & !push_ok; underflow sets on pop & empty.
  - Both hold until clr_err or rst.
  - If clr_err and a new error occur in the same cycle, the set wins.
- Rejected requests never move pointers, count or RAM strobes.

Test Plan:
1. Reset, then 16 single pushes -> count 0..16, ram_wr_add 0..15; almost_full first at count 14; full = 1 after the 16th; overflow = 0.
2. Continue from 1: a 17th push alone -> ram_write = 0, count stays 16, overflow = 1; pulse clr_err -> overflow = 0.
3. Continue from 1: 16 pops -> ram_rd_add 0..15, rd_valid one cycle after each pop, d_out matches push order; empty after the last pop; one extra pop -> underflow = 1, ram_read = 0, rd_valid stays 0.
4. Wrap: push 10, pop 10, push 10 -> ram_wr_add runs 10..15, 0..3; count = 10; subsequent pops return the data in order across the wrap.
5. Simultaneous: push+pop at count 16 -> count 16, both strobes high; push+pop at count 0 -> count 1, underflow = 1; push+pop at count 5 -> count 5.
6. Assert rst asynchronously (mid-cycle) at count 7 with push held high -> outputs reach their reset values immediately without a clock edge; after deassertion, the first push writes address 0.

Source files
------------

// File: rtl/fifo_ctrl_16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_ctrl_16                                                         |
// | Pointer/flag controller turning a 16x8 dual-address RAM into a FIFO. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module fifo_ctrl_16 #(
   parameter int ADDR_W   = 4,
   parameter int AF_LEVEL = 14,
   parameter int AE_LEVEL = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              clr_err,
   output logic              ram_write,
   output logic              ram_read,
   output logic [ADDR_W-1:0] ram_wr_add,
   output logic [ADDR_W-1:0] ram_rd_add,
   output logic              rd_valid,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              overflow,
   output logic              underflow
);

   localparam logic [ADDR_W:0] c_ONE      = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] c_DEPTH    = (ADDR_W+1)'(2**ADDR_W);
   localparam logic [ADDR_W:0] c_AF_LEVEL = (ADDR_W+1)'(AF_LEVEL);
   localparam logic [ADDR_W:0] c_AE_LEVEL = (ADDR_W+1)'(AE_LEVEL);

   logic [ADDR_W:0] r_wr_ptr;
   logic [ADDR_W:0] r_rd_ptr;
   logic [ADDR_W:0] r_count;
   logic            r_rd_valid;
   logic            r_overflow;
   logic            r_underflow;

   logic            w_full;
   logic            w_empty;
   logic            w_pop_ok;
   logic            w_push_ok;

   // Flags come only from the count register, never from the requests.
   assign w_full  = (r_count == c_DEPTH);
   assign w_empty = (r_count == '0);

   // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
   assign w_pop_ok  = pop & ~w_empty;
   assign w_push_ok = push & (~w_full | w_pop_ok);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_rd_valid  <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_push_ok)
            r_wr_ptr <= r_wr_ptr + c_ONE;
         if (w_pop_ok)
            r_rd_ptr <= r_rd_ptr + c_ONE;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + c_ONE;
            2'b01:   r_count <= r_count - c_ONE;
            default: r_count <= r_count;
         endcase
         r_rd_valid <= w_pop_ok;
         // A new error in the same cycle as clr_err keeps the flag set.
         if (push & ~w_push_ok)
            r_overflow <= 1'b1;
         else if (clr_err)
            r_overflow <= 1'b0;
         if (pop & w_empty)
            r_underflow <= 1'b1;
         else if (clr_err)
            r_underflow <= 1'b0;
      end
   end

   assign ram_write    = w_push_ok;
   assign ram_read     = w_pop_ok;
   assign ram_wr_add   = r_wr_ptr[ADDR_W-1:0];
   assign ram_rd_add   = r_rd_ptr[ADDR_W-1:0];
   assign rd_valid     = r_rd_valid;
   assign count        = r_count;
   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= c_AF_LEVEL);
   assign almost_empty = (r_count <= c_AE_LEVEL);
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule
`default_nettype wire
